// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: latch control codes, FSM states and
// the per-cycle event selected by the priority resolver.
// Latency: n/a (types only). Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  // Pipeline latch control encoding. 2'b11 is treated as HOLD by the latches.
  localparam logic [1:0] CTR_LOAD  = 2'b00;
  localparam logic [1:0] CTR_HOLD  = 2'b01;
  localparam logic [1:0] CTR_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DC_WAIT = 2'd1,
    S_EX_BUSY = 2'd2,
    S_IC_WAIT = 2'd3
  } state_t;

  // The single winning event of a cycle; both next-state and output decode key off it.
  typedef enum logic [3:0] {
    EV_RUN,
    EV_DC_STALL,
    EV_DC_REL,
    EV_EX_START,
    EV_EX_STALL,
    EV_EX_REL,
    EV_BRANCH,
    EV_LOAD_USE,
    EV_IC_STALL,
    EV_IC_REL
  } evt_t;

  typedef struct packed {
    logic [1:0] ifid;
    logic [1:0] idex;
    logic [1:0] exmm;
    logic [1:0] mmwb;
    logic       pc_en;
    logic       pc_sel_br;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(input logic [1:0] ifid, input logic [1:0] idex,
                                    input logic [1:0] exmm, input logic [1:0] mmwb,
                                    input logic pc_en, input logic pc_sel_br);
    ctrl_t c;
    c.ifid      = ifid;
    c.idex      = idex;
    c.exmm      = exmm;
    c.mmwb      = mmwb;
    c.pc_en     = pc_en;
    c.pc_sel_br = pc_sel_br;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Load-use hazard detect: flags an ID instruction that reads the register a load in EX writes.
// Latency: purely combinational. Backpressure: none, result is consumed the same cycle.
// Ports: id_rx/id_ry (+_v) ID sources, ex_rd/ex_wr_v/ex_mem_rd EX destination, lu_hazard out.
module lu_detect #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] id_rx,
  input  logic             id_rx_v,
  input  logic [REG_W-1:0] id_ry,
  input  logic             id_ry_v,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wr_v,
  input  logic             ex_mem_rd,
  output logic             lu_hazard
);

  // Register index 0 is not special in this ISA, so it participates in the compare.
  assign lu_hazard = ex_mem_rd && ex_wr_v &&
                     ((id_rx_v && (id_rx == ex_rd)) || (id_ry_v && (id_ry == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: drives IF/ID, ID/EX, EX/MEM, MEM/WB latch controls, PC enable and redirect.
// Latency: outputs combinational from state/cnt/inputs; state, cnt, stall counter registered.
// Backpressure: stalls via HOLD/pc_en=0 for D-miss > EX busy > branch > load-use > I-miss.
// Ports: clk, rst (sync, active-high); decode/EX/cache status in; ctrl_* (2b), pc_en,
//        pc_sel_br, state (debug) and stall_cycles (saturating count of pc_en==0 cycles) out.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int LAT_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rx,
  input  logic [REG_W-1:0] id_ry,
  input  logic             id_rx_v,
  input  logic             id_ry_v,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wr_v,
  input  logic             ex_mem_rd,
  input  logic             ex_multi,
  input  logic [LAT_W-1:0] ex_lat,
  input  logic             ex_br_taken,
  input  logic             ic_miss,
  input  logic             ic_ready,
  input  logic             dc_miss,
  input  logic             dc_ready,
  output logic [1:0]       ctrl_ifid,
  output logic [1:0]       ctrl_idex,
  output logic [1:0]       ctrl_exmm,
  output logic [1:0]       ctrl_mmwb,
  output logic             pc_en,
  output logic             pc_sel_br,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t           state_q, state_nxt;
  state_t           ret_q, ret_nxt;     // where DC_WAIT returns to once the refill lands
  logic [LAT_W-1:0] cnt_q, cnt_nxt;     // remaining EX_BUSY stall cycles before release
  evt_t             evt;
  logic             lu_hazard;
  ctrl_t            ctl;

  lu_detect #(.REG_W(REG_W)) u_lu_detect (
    .id_rx     (id_rx),
    .id_rx_v   (id_rx_v),
    .id_ry     (id_ry),
    .id_ry_v   (id_ry_v),
    .ex_rd     (ex_rd),
    .ex_wr_v   (ex_wr_v),
    .ex_mem_rd (ex_mem_rd),
    .lu_hazard (lu_hazard)
  );

  // State register, busy counter, return state and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      ret_q        <= S_RUN;
      cnt_q        <= '0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_nxt;
      ret_q   <= ret_nxt;
      cnt_q   <= cnt_nxt;
      if (!ctl.pc_en && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Priority resolver. A pending D-cache wait owns the pipe until dc_ready; an EX_BUSY
  // sequence then blocks everything younger; the rest only act in RUN/IC_WAIT.
  always_comb begin
    evt = EV_RUN;
    if (state_q == S_DC_WAIT)
      evt = dc_ready ? EV_DC_REL : EV_DC_STALL;
    else if (dc_miss)
      evt = EV_DC_STALL;
    else if (state_q == S_EX_BUSY)
      evt = (cnt_q != '0) ? EV_EX_STALL : EV_EX_REL;
    else if ((state_q == S_RUN) && ex_multi && (ex_lat >= LAT_W'(2)))
      evt = EV_EX_START;
    else if (ex_br_taken)
      evt = EV_BRANCH;
    else if (lu_hazard)
      evt = EV_LOAD_USE;
    else if (state_q == S_IC_WAIT)
      evt = ic_ready ? EV_IC_REL : EV_IC_STALL;
    else if (ic_miss)
      evt = EV_IC_STALL;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    ret_nxt   = ret_q;
    cnt_nxt   = cnt_q;
    case (evt)
      EV_DC_STALL: begin
        state_nxt = S_DC_WAIT;
        // Only an EX_BUSY sequence is resumed; an abandoned I-miss is re-raised by the cache.
        if (state_q != S_DC_WAIT)
          ret_nxt = (state_q == S_EX_BUSY) ? S_EX_BUSY : S_RUN;
      end
      EV_DC_REL:   state_nxt = ret_q;
      EV_EX_START: begin
        // First EX cycle is this one and the release cycle is the last, hence lat-2.
        state_nxt = S_EX_BUSY;
        cnt_nxt   = ex_lat - LAT_W'(2);
      end
      EV_EX_STALL: cnt_nxt = cnt_q - LAT_W'(1);
      EV_EX_REL,
      EV_BRANCH,
      EV_IC_REL:   state_nxt = S_RUN;
      EV_IC_STALL: state_nxt = S_IC_WAIT;
      default:     ;
    endcase
  end

  // Output decode.
  always_comb begin
    ctl = mk_ctrl(CTR_LOAD, CTR_LOAD, CTR_LOAD, CTR_LOAD, 1'b1, 1'b0);
    if (rst) begin
      ctl = mk_ctrl(CTR_FLUSH, CTR_FLUSH, CTR_FLUSH, CTR_FLUSH, 1'b0, 1'b0);
    end else begin
      case (evt)
        EV_DC_STALL: ctl = mk_ctrl(CTR_HOLD,  CTR_HOLD,  CTR_HOLD,  CTR_FLUSH, 1'b0, 1'b0);
        EV_EX_START,
        EV_EX_STALL: ctl = mk_ctrl(CTR_HOLD,  CTR_HOLD,  CTR_FLUSH, CTR_LOAD,  1'b0, 1'b0);
        EV_BRANCH:   ctl = mk_ctrl(CTR_FLUSH, CTR_FLUSH, CTR_LOAD,  CTR_LOAD,  1'b1, 1'b1);
        EV_LOAD_USE: ctl = mk_ctrl(CTR_HOLD,  CTR_FLUSH, CTR_LOAD,  CTR_LOAD,  1'b0, 1'b0);
        EV_IC_STALL: ctl = mk_ctrl(CTR_FLUSH, CTR_LOAD,  CTR_LOAD,  CTR_LOAD,  1'b0, 1'b0);
        default:     ;
      endcase
    end
  end

  assign ctrl_ifid = ctl.ifid;
  assign ctrl_idex = ctl.idex;
  assign ctrl_exmm = ctl.exmm;
  assign ctrl_mmwb = ctl.mmwb;
  assign pc_en     = ctl.pc_en;
  assign pc_sel_br = ctl.pc_sel_br;
  assign state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic, every cycle
// checked against a cycle-level reference model through an expected-response queue.
// Small stall counter width so saturation is reached within the run.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 4;
  localparam int LAT_W = 4;
  localparam int CNT_W = 6;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rx, id_ry, ex_rd;
  logic             id_rx_v, id_ry_v, ex_wr_v, ex_mem_rd, ex_multi, ex_br_taken;
  logic [LAT_W-1:0] ex_lat;
  logic             ic_miss, ic_ready, dc_miss, dc_ready;
  logic [1:0]       ctrl_ifid, ctrl_idex, ctrl_exmm, ctrl_mmwb, state;
  logic             pc_en, pc_sel_br;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(REG_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rx(id_rx), .id_ry(id_ry), .id_rx_v(id_rx_v), .id_ry_v(id_ry_v),
    .ex_rd(ex_rd), .ex_wr_v(ex_wr_v), .ex_mem_rd(ex_mem_rd),
    .ex_multi(ex_multi), .ex_lat(ex_lat), .ex_br_taken(ex_br_taken),
    .ic_miss(ic_miss), .ic_ready(ic_ready), .dc_miss(dc_miss), .dc_ready(dc_ready),
    .ctrl_ifid(ctrl_ifid), .ctrl_idex(ctrl_idex), .ctrl_exmm(ctrl_exmm), .ctrl_mmwb(ctrl_mmwb),
    .pc_en(pc_en), .pc_sel_br(pc_sel_br), .state(state), .stall_cycles(stall_cycles)
  );

  typedef struct {
    bit             rst;
    bit [REG_W-1:0] id_rx, id_ry, ex_rd;
    bit             id_rx_v, id_ry_v, ex_wr_v, ex_mem_rd, ex_multi, ex_br_taken;
    bit [LAT_W-1:0] ex_lat;
    bit             ic_miss, ic_ready, dc_miss, dc_ready;
  } stim_t;

  typedef struct {
    bit [1:0] ifid, idex, exmm, mmwb;
    bit       pc_en, br;
    bit [1:0] st;
    int       stall;
    bit       regs_known;   // DUT registers are X until the first reset edge
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: pending conditions rather than a state code.
  bit m_dc    = 1'b0;   // waiting on D-cache refill
  int m_busy  = 0;      // EX cycles still to come in a multi-cycle op (last one releases)
  bit m_ic    = 1'b0;   // waiting on I-cache refill
  int m_stall = 0;
  bit m_known = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst         = ($urandom_range(199) == 0);
    s.id_rx       = REG_W'($urandom_range(3));
    s.id_ry       = REG_W'($urandom_range(3));
    s.ex_rd       = REG_W'($urandom_range(3));
    s.id_rx_v     = ($urandom_range(1) == 0);
    s.id_ry_v     = ($urandom_range(1) == 0);
    s.ex_wr_v     = ($urandom_range(3) != 0);
    s.ex_mem_rd   = ($urandom_range(2) == 0);
    s.ex_multi    = ($urandom_range(9) == 0);
    s.ex_lat      = LAT_W'($urandom_range(6));
    s.ex_br_taken = ($urandom_range(6) == 0);
    s.ic_miss     = ($urandom_range(7) == 0);
    s.ic_ready    = ($urandom_range(2) == 0);
    s.dc_miss     = ($urandom_range(15) == 0);
    s.dc_ready    = ($urandom_range(2) == 0);
    return s;
  endfunction

  task automatic set_out(output exp_t e, input bit [1:0] a, input bit [1:0] b,
                         input bit [1:0] c, input bit [1:0] d, input bit pe, input bit br);
    e.ifid = a; e.idex = b; e.exmm = c; e.mmwb = d; e.pc_en = pe; e.br = br;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit lu;
    lu = s.ex_mem_rd && s.ex_wr_v &&
         ((s.id_rx_v && s.id_rx == s.ex_rd) || (s.id_ry_v && s.id_ry == s.ex_rd));
    e.st         = m_dc ? 2'd1 : (m_busy > 0) ? 2'd2 : m_ic ? 2'd3 : 2'd0;
    e.stall      = m_stall;
    e.regs_known = m_known;
    set_out(e, 0, 0, 0, 0, 1, 0);
    if (s.rst) begin
      set_out(e, 2, 2, 2, 2, 0, 0);
      m_dc = 0; m_busy = 0; m_ic = 0; m_stall = 0; m_known = 1;
      return;
    end
    if (m_dc) begin
      if (!s.dc_ready) set_out(e, 1, 1, 1, 2, 0, 0);
      else m_dc = 0;
    end else if (s.dc_miss) begin
      set_out(e, 1, 1, 1, 2, 0, 0);
      m_dc = 1;
      m_ic = 0;
    end else if (m_busy > 0) begin
      if (m_busy > 1) set_out(e, 1, 1, 2, 0, 0, 0);
      m_busy--;
    end else if (!m_ic && s.ex_multi && s.ex_lat >= 2) begin
      set_out(e, 1, 1, 2, 0, 0, 0);
      m_busy = int'(s.ex_lat) - 1;
    end else if (s.ex_br_taken) begin
      set_out(e, 2, 2, 0, 0, 1, 1);
      m_ic = 0;
    end else if (lu) begin
      set_out(e, 1, 2, 0, 0, 0, 0);
    end else if (m_ic) begin
      if (!s.ic_ready) set_out(e, 2, 0, 0, 0, 0, 0);
      else m_ic = 0;
    end else if (s.ic_miss) begin
      set_out(e, 2, 0, 0, 0, 0, 0);
      m_ic = 1;
    end
    if (!e.pc_en && m_stall < SAT) m_stall++;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; id_rx = s.id_rx; id_ry = s.id_ry; ex_rd = s.ex_rd;
    id_rx_v = s.id_rx_v; id_ry_v = s.id_ry_v; ex_wr_v = s.ex_wr_v; ex_mem_rd = s.ex_mem_rd;
    ex_multi = s.ex_multi; ex_lat = s.ex_lat; ex_br_taken = s.ex_br_taken;
    ic_miss = s.ic_miss; ic_ready = s.ic_ready; dc_miss = s.dc_miss; dc_ready = s.dc_ready;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) apply(idle());
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs; check mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl_ifid", 32'(ctrl_ifid), 32'(e.ifid));
        chk("ctrl_idex", 32'(ctrl_idex), 32'(e.idex));
        chk("ctrl_exmm", 32'(ctrl_exmm), 32'(e.exmm));
        chk("ctrl_mmwb", 32'(ctrl_mmwb), 32'(e.mmwb));
        chk("pc_en", 32'(pc_en), 32'(e.pc_en));
        chk("pc_sel_br", 32'(pc_sel_br), 32'(e.br));
        if (e.regs_known) begin
          chk("state", 32'(state), 32'(e.st));
          chk("stall_cycles", 32'(stall_cycles), 32'(e.stall));
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    rst = 1'b1; id_rx = '0; id_ry = '0; ex_rd = '0; id_rx_v = 0; id_ry_v = 0;
    ex_wr_v = 0; ex_mem_rd = 0; ex_multi = 0; ex_lat = '0; ex_br_taken = 0;
    ic_miss = 0; ic_ready = 0; dc_miss = 0; dc_ready = 0;

    s = idle(); s.rst = 1;
    repeat (3) apply(s);
    idles(2);

    // Load-use on rx=5, then clear.
    s = idle(); s.ex_mem_rd = 1; s.ex_wr_v = 1; s.ex_rd = 5; s.id_rx = 5; s.id_rx_v = 1;
    apply(s);
    idles(1);
    // Index 0 on ry is an ordinary hazard; the same compare with ex_wr_v low is not.
    s = idle(); s.ex_mem_rd = 1; s.ex_wr_v = 1; s.ex_rd = 0; s.id_ry = 0; s.id_ry_v = 1;
    apply(s);
    s.ex_wr_v = 0;
    apply(s);

    // Multi-cycle op, latency 4.
    s = idle(); s.ex_multi = 1; s.ex_lat = 4;
    apply(s);
    idles(4);
    // Latencies 0, 1 and 2 at the single-cycle boundary.
    for (int l = 0; l < 3; l++) begin
      s = idle(); s.ex_multi = 1; s.ex_lat = LAT_W'(l);
      apply(s);
      idles(2);
    end

    // D-miss held six cycles, then refill.
    s = idle(); s.dc_miss = 1;
    apply(s);
    s = idle();
    repeat (5) apply(s);
    s.dc_ready = 1;
    apply(s);
    idles(2);

    // Taken branch with coincident load-use and I-miss.
    s = idle(); s.ex_br_taken = 1; s.ic_miss = 1;
    s.ex_mem_rd = 1; s.ex_wr_v = 1; s.ex_rd = 3; s.id_rx = 3; s.id_rx_v = 1;
    apply(s);
    idles(1);
    // I-miss, two wait cycles, then a branch abandons it.
    s = idle(); s.ic_miss = 1;
    apply(s);
    idles(2);
    s = idle(); s.ex_br_taken = 1;
    apply(s);
    idles(1);

    // D-miss during EX_BUSY with cnt=2; busy resumes afterwards.
    s = idle(); s.ex_multi = 1; s.ex_lat = 4;
    apply(s);
    s = idle(); s.dc_miss = 1;
    apply(s);
    idles(3);
    s = idle(); s.dc_ready = 1;
    apply(s);
    idles(4);

    // Reset applied for three cycles in the middle of a D-cache wait.
    s = idle(); s.dc_miss = 1;
    apply(s);
    idles(2);
    s = idle(); s.rst = 1;
    repeat (3) apply(s);
    idles(2);

    // Random traffic.
    for (int i = 0; i < 4000; i++) apply(rand_stim());
    idles(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
